// File: rtl/merge_rr_buffer_pkg.sv
// Shared definitions for the round-robin merge buffer: buffer state encoding
// and index-width / wrap helpers used by the top and the priority selector.
package merge_rr_buffer_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  // ceil(log2(n)) clamped to at least 1 so a single-input build still has an index bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  // (base + off) mod n for base, off in [0, n); no divider needed
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/merge_rr_buffer_select.sv
// Combinational rotating-priority selector: first valid requester at or after ptr,
// wrapping modulo N. Reusable by any shared-resource arbiter.
module rr_priority_select
  import merge_rr_buffer_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  // Scan from lowest priority to highest so the highest-priority hit overwrites.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_valid = |valid;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[wrap_add(int'(ptr), k, N)]) begin
        grant                              = '0;
        grant[wrap_add(int'(ptr), k, N)]   = 1'b1;
        winner                             = IDX_W'(wrap_add(int'(ptr), k, N));
      end
    end
  end

endmodule

// File: rtl/merge_rr_buffer.sv
// Round-robin merge of NUM_INPUTS elastic producers into one registered output slot,
// tagging each token with the input number it came from.
module merge_rr_buffer
  import merge_rr_buffer_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  parameter  int DATA_TYPE  = 32,
  localparam int IDX_W      = clog2_min1(NUM_INPUTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_INPUTS*DATA_TYPE-1:0] ins,
  input  logic [NUM_INPUTS-1:0]           ins_valid,
  output logic [NUM_INPUTS-1:0]           ins_ready,
  output logic [DATA_TYPE-1:0]            outs,
  output logic                            outs_valid,
  input  logic                            outs_ready,
  output logic [IDX_W-1:0]                index
);

  // state    | meaning
  // ST_EMPTY | no token held, any valid input may load
  // ST_FULL  | token held on outs; reload only when the consumer takes it

  buf_state_e             state, state_nxt;
  logic [IDX_W-1:0]       ptr, ptr_nxt;
  logic [IDX_W-1:0]       winner;
  logic [NUM_INPUTS-1:0]  grant;
  logic                   any_valid;
  logic                   can_load;
  logic                   load;
  logic [DATA_TYPE-1:0]   sel_data;
  logic [DATA_TYPE-1:0]   data_r;
  logic [IDX_W-1:0]       index_r;

  rr_priority_select #(
    .N     (NUM_INPUTS),
    .IDX_W (IDX_W)
  ) u_sel (
    .valid     (ins_valid),
    .ptr       (ptr),
    .grant     (grant),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_EMPTY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (load) state_nxt = ST_FULL;
      ST_FULL:  if (!load && outs_ready) state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    outs_valid = (state == ST_FULL);
    can_load   = !outs_valid || outs_ready;
    load       = any_valid && can_load;
    ins_ready  = can_load ? grant : '0;
  end

  // Explicit wrap keeps non-power-of-two counts from stepping into unused codes.
  always_comb begin
    ptr_nxt = ptr;
    if (load) begin
      if (int'(winner) == NUM_INPUTS - 1) ptr_nxt = '0;
      else                                ptr_nxt = winner + IDX_W'(1);
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) sel_data = ins[i*DATA_TYPE +: DATA_TYPE];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r  <= '0;
      index_r <= '0;
    end else if (load) begin
      data_r  <= sel_data;
      index_r <= winner;
    end
  end

  assign outs  = data_r;
  assign index = index_r;

endmodule

// File: tb/tb_merge_rr_buffer.sv
// Directed + random checks of merge_rr_buffer at N=4 and N=3 against a queue scoreboard.
module tb_merge_rr_buffer;

  localparam int N4 = 4;
  localparam int W4 = 32;
  localparam int N3 = 3;
  localparam int W3 = 16;

  typedef struct {
    logic [31:0] data;
    int          idx;
  } tok_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [N4*W4-1:0] ins;
  logic [N4-1:0]    ins_valid, ins_ready;
  logic [W4-1:0]    outs;
  logic             outs_valid, outs_ready;
  logic [1:0]       index;

  logic [N3*W3-1:0] ins3;
  logic [N3-1:0]    ins_valid3, ins_ready3;
  logic [W3-1:0]    outs3;
  logic             outs_valid3, outs_ready3;
  logic [1:0]       index3;

  merge_rr_buffer #(.NUM_INPUTS(N4), .DATA_TYPE(W4)) dut4 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready), .index(index)
  );

  merge_rr_buffer #(.NUM_INPUTS(N3), .DATA_TYPE(W3)) dut3 (
    .clk(clk), .rst(rst), .ins(ins3), .ins_valid(ins_valid3), .ins_ready(ins_ready3),
    .outs(outs3), .outs_valid(outs_valid3), .outs_ready(outs_ready3), .index(index3)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  tok_t q4[$];
  tok_t q3[$];
  int   mptr4, mptr3;
  bit   mfull4, mfull3;

  function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic int pick(input logic [3:0] v, input int n, input int p);
    for (int k = 0; k < n; k++) begin
      if (v[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    q4.delete();
    q3.delete();
    mptr4  = 0;
    mptr3  = 0;
    mfull4 = 1'b0;
    mfull3 = 1'b0;
  endfunction

  function automatic void eval4(input string tag);
    int w;
    bit can;
    logic [3:0] er;
    tok_t t;
    w   = pick(ins_valid, N4, mptr4);
    can = !mfull4 || outs_ready;
    er  = (w >= 0 && can) ? 4'(1 << w) : 4'b0;
    check({tag, "/rdy4"}, 64'(ins_ready), 64'(er));
    check({tag, "/vld4"}, 64'(outs_valid), 64'(mfull4));
    if (mfull4 && q4.size() > 0) begin
      t = q4[0];
      check({tag, "/dat4"}, 64'(outs), 64'(t.data));
      check({tag, "/idx4"}, 64'(index), 64'(t.idx));
      if (outs_ready) void'(q4.pop_front());
    end
    if (w >= 0 && can) begin
      t.data = ins[w*W4 +: W4];
      t.idx  = w;
      q4.push_back(t);
      mptr4  = (w + 1) % N4;
      mfull4 = 1'b1;
    end else if (mfull4 && outs_ready) begin
      mfull4 = 1'b0;
    end
  endfunction

  function automatic void eval3(input string tag);
    int w;
    bit can;
    logic [2:0] er;
    tok_t t;
    w   = pick({1'b0, ins_valid3}, N3, mptr3);
    can = !mfull3 || outs_ready3;
    er  = (w >= 0 && can) ? 3'(1 << w) : 3'b0;
    check({tag, "/rdy3"}, 64'(ins_ready3), 64'(er));
    check({tag, "/vld3"}, 64'(outs_valid3), 64'(mfull3));
    if (mfull3 && q3.size() > 0) begin
      t = q3[0];
      check({tag, "/dat3"}, 64'(outs3), 64'(t.data));
      check({tag, "/idx3"}, 64'(index3), 64'(t.idx));
      if (outs_ready3) void'(q3.pop_front());
    end
    if (w >= 0 && can) begin
      t.data = 32'(ins3[w*W3 +: W3]);
      t.idx  = w;
      q3.push_back(t);
      mptr3  = (w + 1) % N3;
      mfull3 = 1'b1;
    end else if (mfull3 && outs_ready3) begin
      mfull3 = 1'b0;
    end
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N4; i++) ins[i*W4 +: W4] = $urandom;
    for (int i = 0; i < N3; i++) ins3[i*W3 +: W3] = 16'($urandom);
  endtask

  // Inputs are driven 1 time unit after a rising edge; checks happen 1 unit later.
  task automatic step(input string tag);
    #1;
    eval4(tag);
    eval3(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    ins         = '0;
    ins_valid   = '0;
    outs_ready  = 1'b1;
    ins3        = '0;
    ins_valid3  = '0;
    outs_ready3 = 1'b1;
    model_reset();

    // Reset and single load
    ins[1*W4 +: W4] = 32'h0000_00A5;
    ins_valid       = 4'b0010;
    @(posedge clk); #1;
    @(posedge clk); #3;
    check("rst/vld4", 64'(outs_valid), 64'd0);
    check("rst/dat4", 64'(outs), 64'd0);
    check("rst/idx4", 64'(index), 64'd0);
    check("rst/rdy4", 64'(ins_ready), 64'b0010);
    check("rst/vld3", 64'(outs_valid3), 64'd0);
    rst = 1'b1;
    step("load");
    ins_valid = 4'b1111;
    rand_data();
    step("ptr2");
    rand_data();
    step("ptr3");

    // Rotation: all valid, expect 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step("rot");
    end

    // Back-pressure with index 2 held
    ins_valid = 4'b0100;
    rand_data();
    step("bp_load");
    ins_valid  = 4'b1111;
    outs_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step("bp_hold");
    end
    outs_ready = 1'b1;
    rand_data();
    step("bp_reload");
    ins_valid = 4'b0000;
    step("bp_drain");
    step("bp_empty");

    // Non-power-of-two wrap on the N=3 instance
    ins_valid3 = 3'b101;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step("wrap3");
    end

    // Random traffic on both instances
    for (int i = 0; i < 60; i++) begin
      ins_valid   = 4'($urandom);
      ins_valid3  = 3'($urandom);
      outs_ready  = 1'($urandom);
      outs_ready3 = 1'($urandom);
      rand_data();
      step("rand");
    end

    // Mid-operation asynchronous reset while holding 0x1234
    ins_valid   = '0;
    ins_valid3  = '0;
    outs_ready  = 1'b1;
    outs_ready3 = 1'b1;
    step("drain");
    step("drain2");
    ins[0 +: W4] = 32'h0000_1234;
    ins_valid    = 4'b0001;
    step("pre_rst");
    ins_valid  = 4'b0000;
    outs_ready = 1'b0;
    #2;
    check("pre_rst/dat4", 64'(outs), 64'h1234);
    check("pre_rst/vld4", 64'(outs_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst/vld4", 64'(outs_valid), 64'd0);
    check("async_rst/dat4", 64'(outs), 64'd0);
    check("async_rst/idx4", 64'(index), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst        = 1'b1;
    outs_ready = 1'b1;
    ins_valid  = 4'b1111;
    rand_data();
    step("post_rst");
    ins_valid = 4'b0000;
    step("post_rst2");
    step("post_rst3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/merge_rr_buffer.md
# merge_rr_buffer

Round-robin merge controller that shares a single one-slot opaque output buffer between NUM_INPUTS elastic producers. Each cycle it selects one valid input and loads its token into the output register. It also records which input won, so downstream muxes and branch logic can steer on it. It sits where several dataflow paths converge into one shared unit: a fair, registered, full-throughput merge that breaks the combinational valid/data path.

## Interface
- NUM_INPUTS, default 4: number of producer channels, ≥1.
- DATA_TYPE, default 32: token data width, ≥1.
- IDX_W, derived and not overridable: max(1, ceil(log2(NUM_INPUTS))).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Asserted (0) clears all state immediately.
- ins  in  NUM_INPUTS*DATA_TYPE  flattened input data; channel i occupies bits [i*DATA_TYPE +: DATA_TYPE].
- ins_valid  in  NUM_INPUTS  per-channel valid.
- ins_ready  out  NUM_INPUTS  per-channel ready.
- outs  out  DATA_TYPE  buffered token.
- outs_valid  out  1  buffer holds a token.
- outs_ready  in  1  consumer ready.
- index  out  IDX_W  input number of the token in `outs`; registered together with the data.

## Operation
- Control states:
  - EMPTY (outs_valid=0) and FULL (outs_valid=1).
  - Data and index registers are written only on an input transfer.
- Priority pointer `ptr` (0..NUM_INPUTS-1):
  - Priority order is ptr, ptr+1, …, wrapping modulo NUM_INPUTS.
  - The winner `w` is the first valid input in that order.
  - When no input is valid, there is no grant.
- Acceptance: `can_load = !outs_valid | outs_ready`.
- Ready: ins_ready[i] = (i == w) & any_valid & can_load. At most one bit is high.
- Input transfer (ins_valid[w] & ins_ready[w]):
  - outs ← ins[w], index ← w, outs_valid ← 1.
  - ptr ← (w+1) mod NUM_INPUTS. Wrap is explicit for non-power-of-two counts.
- Output transfer without a load: outs_valid ← 0. outs and index hold their stale value.
- Simultaneous output transfer and load: the new token replaces the old one with no bubble, and outs_valid stays 1.
- FULL with outs_ready=0: all ins_ready=0, and outs, index and outs_valid are held stable.
- ptr changes only on an input transfer. No transfer means no pointer movement.
- A losing producer keeps valid asserted, per the elastic protocol. The grant may move to a newly valid input earlier in priority order; this is legal because no transfer has occurred.
- NUM_INPUTS=1 degenerates to a plain opaque buffer: index is always 0 and ptr is constant 0.
- Reset (rst=0) at any time, including mid-transfer:
  - Outputs: outs_valid=0, outs=0, index=0.
  - Internal: ptr=0.
  - Any stored token is dropped.
  - ins_ready follows combinationally from the reset state, so it is high for the granted valid input.

## Timing
- Latency 1 cycle: a token accepted at edge k is on outs with outs_valid=1 after edge k.
- Throughput: one token per cycle while outs_ready=1 and any input is valid.
- Combinational paths:
  - ins_valid → ins_ready.
  - outs_ready → ins_ready.
  - No combinational path from any input to outs, outs_valid or index.
- Fairness: with all inputs continuously valid and outs_ready=1, grant order is 0,1,…,N-1,0,…, and each input is served within NUM_INPUTS transfers.
- Reset release: the first load can occur at the first rising edge after rst goes high.

## Structure
- Shared package:
  - IDX_W computation: clog2 function clamped to ≥1.
  - EMPTY/FULL state encoding constants.
- Sub-module `rr_priority_select`:
  - Purely combinational.
  - Inputs: valid vector, ptr.
  - Outputs: one-hot grant, binary winner index, any_valid.
  - Intended for reuse by other shared-resource arbiters.
- Top level holds ptr, outs_valid, and the data/index registers.

## Test plan
- Reset and single load:
  - Stimulus: hold rst=0, then release; ins_valid=0010, ins[1]=0xA5, outs_ready=1.
  - Response: during reset, outs_valid=0, outs=0, index=0. One cycle after release, outs=0xA5, index=1, ptr=2.
- Rotation (N=4):
  - Stimulus: all valid, outs_ready=1 for 8 cycles.
  - Response: index sequence 0,1,2,3,0,1,2,3; one transfer per cycle, no bubbles.
- Back-pressure:
  - Stimulus: FULL with index=2; outs_ready=0 for 3 cycles.
  - Response: ins_ready=0000, outs and index stable, ptr unchanged. On outs_ready=1, a same-cycle reload occurs and outs_valid stays 1.
- Non-power-of-two wrap:
  - Stimulus: NUM_INPUTS=3 with only inputs 0 and 2 valid.
  - Response: index sequence 0,2,0,2; ptr wraps 2→0.
- Mid-operation reset:
  - Stimulus: assert rst=0 asynchronously (not at a clock edge) while FULL with outs=0x1234.
  - Response: outs_valid=0, outs=0 and index=0 immediately, before the next edge; ptr restarts at 0.
